// File: rtl/alu_issue_seq_if.sv
// Issue sequencer bundle: upstream op handshake, ALU drive/return and
// result/status outputs.
interface alu_issue_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [5:0]  alu_signal;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [31:0] alu_result;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_hi;
    logic        err;
    logic        busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_result,
        output in_ready, alu_signal, alu_dataA, alu_dataB,
        output res_valid, res_data, res_hi, err, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, alu_result,
        input  in_ready, alu_signal, alu_dataA, alu_dataB,
        input  res_valid, res_data, res_hi, err, busy
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Buffers ALU operations in a small FIFO and sequences them onto a
// single-cycle-latency ALU, including the long MULTU / Hi / Lo readout.
module alu_issue_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int MULT_HOLD  = 35
) (
    input  logic           clk,
    input  logic           reset,
    alu_issue_seq_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MULT_HOLD + 1);
    localparam logic [PW:0]   PONE     = 1;
    localparam logic [CW-1:0] CONE     = 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MULT_HOLD - 1);

    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_CAP, S_MUL, S_MFHI, S_HICAP, S_LOCAP
    } state_t;

    entry_t        mem_q [FIFO_DEPTH];
    logic [PW:0]   wptr_q, rptr_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    sig_q, sig_d;
    logic [31:0]   da_q, da_d, db_q, db_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          rv_q, rv_d, rhi_q, rhi_d, err_q, err_d;

    logic   full, empty, push, pop, is_simple, is_mul;
    entry_t head;

    // Extra pointer bit distinguishes full from empty on equal indices.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign head  = mem_q[rptr_q[PW-1:0]];

    always_comb begin
        is_simple = 1'b0;
        is_mul    = 1'b0;
        case (head.op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
            OP_SRL, OP_MFHI, OP_MFLO: is_simple = 1'b1;
            OP_MULTU:                 is_mul    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q[PW-1:0]] <= {bus.in_op, bus.in_a, bus.in_b};
                wptr_q <= wptr_q + PONE;
            end
            if (pop) rptr_q <= rptr_q + PONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
            da_q    <= '0;
            db_q    <= '0;
            rdat_q  <= '0;
            rv_q    <= 1'b0;
            rhi_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            da_q    <= da_d;
            db_q    <= db_d;
            rdat_q  <= rdat_d;
            rv_q    <= rv_d;
            rhi_q   <= rhi_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop && is_simple) state_d = S_EXEC;
                else if (pop && is_mul) state_d = S_MUL;
            end
            S_EXEC:  state_d = S_CAP;
            S_CAP:   state_d = S_IDLE;
            S_MUL:   if (cnt_q == CNT_LAST) state_d = S_MFHI;
            S_MFHI:  state_d = S_HICAP;
            S_HICAP: state_d = S_LOCAP;
            S_LOCAP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered-output next values; result/err are single-cycle pulses.
    always_comb begin
        cnt_d  = cnt_q;
        sig_d  = sig_q;
        da_d   = da_q;
        db_d   = db_q;
        rdat_d = rdat_q;
        rhi_d  = rhi_q;
        rv_d   = 1'b0;
        err_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sig_d = '0;
                if (pop) begin
                    if (is_simple || is_mul) begin
                        sig_d = head.op;
                        da_d  = head.a;
                        db_d  = head.b;
                        cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_EXEC: ;
            S_CAP: begin
                rdat_d = bus.alu_result;
                rhi_d  = 1'b0;
                rv_d   = 1'b1;
                sig_d  = '0;
            end
            S_MUL: begin
                cnt_d = cnt_q + CONE;
                if (cnt_q == CNT_LAST) begin
                    sig_d = OP_MFHI;
                    cnt_d = '0;
                end
            end
            S_MFHI:  sig_d = OP_MFLO;
            S_HICAP: begin
                rdat_d = bus.alu_result;
                rhi_d  = 1'b1;
                rv_d   = 1'b1;
            end
            S_LOCAP: begin
                rdat_d = bus.alu_result;
                rhi_d  = 1'b0;
                rv_d   = 1'b1;
                sig_d  = '0;
            end
            default: ;
        endcase
    end

    assign bus.in_ready   = reset && !full;
    assign bus.busy       = !empty || (state_q != S_IDLE);
    assign bus.alu_signal = sig_q;
    assign bus.alu_dataA  = da_q;
    assign bus.alu_dataB  = db_q;
    assign bus.res_valid  = rv_q;
    assign bus.res_data   = rdat_q;
    assign bus.res_hi     = rhi_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq with a behavioural one-cycle ALU
// and a queue-based reference model of the expected result stream.
module tb_alu_issue_seq;
    localparam int DEPTH = 4;
    localparam int HOLD  = 35;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_issue_seq_if bus();

    alu_issue_seq #(.FIFO_DEPTH(DEPTH), .MULT_HOLD(HOLD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc = 0;
    int res_pulses = 0;
    int err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: registered output, MULTU writes Hi/Lo.
    logic [31:0] alu_hi = 0;
    logic [31:0] alu_lo = 0;
    always @(posedge clk) begin
        case (bus.alu_signal)
            6'd36: bus.alu_result <= bus.alu_dataA & bus.alu_dataB;
            6'd37: bus.alu_result <= bus.alu_dataA | bus.alu_dataB;
            6'd32: bus.alu_result <= bus.alu_dataA + bus.alu_dataB;
            6'd34: bus.alu_result <= bus.alu_dataA - bus.alu_dataB;
            6'd42: bus.alu_result <= ($signed(bus.alu_dataA) < $signed(bus.alu_dataB)) ? 32'd1 : 32'd0;
            6'd2:  bus.alu_result <= bus.alu_dataA >> bus.alu_dataB[4:0];
            6'd25: {alu_hi, alu_lo} <= {32'd0, bus.alu_dataA} * {32'd0, bus.alu_dataB};
            6'd16: bus.alu_result <= alu_hi;
            6'd18: bus.alu_result <= alu_lo;
            default: bus.alu_result <= 32'd0;
        endcase
    end

    typedef struct {
        bit          is_err;
        logic [31:0] d;
        bit          hi;
    } exp_t;

    exp_t expq[$];
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    function automatic void model_issue(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        e.is_err = 0;
        e.hi = 0;
        e.d = 0;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            6'd36: e.d = a & b;
            6'd37: e.d = a | b;
            6'd32: e.d = a + b;
            6'd34: e.d = a - b;
            6'd42: e.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd2:  e.d = a >> (b % 32);
            6'd16: e.d = m_hi;
            6'd18: e.d = m_lo;
            6'd25: begin
                m_hi = p[63:32];
                m_lo = p[31:0];
                e.d = m_hi;
                e.hi = 1;
                expq.push_back(e);
                e.d = m_lo;
                e.hi = 0;
            end
            default: e.is_err = 1;
        endcase
        expq.push_back(e);
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", n, act, exp);
        end
    endtask

    exp_t got;
    always @(negedge clk) begin
        if (bus.res_valid || bus.err)
            chk("res_err_exclusive", {31'd0, bus.res_valid && bus.err}, 32'd0);
        if (bus.res_valid) begin
            res_pulses++;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got=%0h hi=%0d exp=none", bus.res_data, bus.res_hi);
            end else begin
                got = expq.pop_front();
                if (got.is_err || got.d !== bus.res_data || got.hi !== bus.res_hi) begin
                    errors++;
                    $display("FAIL sb_result got=%0h hi=%0d exp=%0h hi=%0d err_exp=%0d",
                             bus.res_data, bus.res_hi, got.d, got.hi, got.is_err);
                end
            end
        end
        if (bus.err) begin
            err_pulses++;
            checks++;
            if (expq.size() == 0 || !expq[0].is_err) begin
                errors++;
                $display("FAIL sb_err got=err exp=%s", expq.size() == 0 ? "none" : "result");
                if (expq.size() != 0) void'(expq.pop_front());
            end else begin
                void'(expq.pop_front());
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_a = a;
        bus.in_b = b;
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_issue(op, a, b);
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(input int lim, output int c);
        int t;
        t = 0;
        c = -1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.res_valid && t < lim);
        if (bus.res_valid) c = cyc;
        else chk("wait_res_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input int lim);
        int t;
        t = 0;
        while ((expq.size() != 0 || bus.busy) && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", expq.size(), 32'd0);
        chk("drain_not_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
        chk({tag, "_res_hi"}, {31'd0, bus.res_hi}, 32'd0);
        chk({tag, "_res_data"}, bus.res_data, 32'd0);
        chk({tag, "_alu_signal"}, {26'd0, bus.alu_signal}, 32'd0);
        chk({tag, "_alu_dataA"}, bus.alu_dataA, 32'd0);
        chk({tag, "_alu_dataB"}, bus.alu_dataB, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, hc, lc, n25, m_acc, e0, r0, op, sel;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_a = '0;
        bus.in_b = '0;

        #12;
        chk_reset_outs("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // ADD: accept edge N -> result after edge N+3
        send(6'd32, 32'd5, 32'd7);
        wait_res(20, c);
        chk("add_latency", c - acc, 32'd3);
        chk("add_data", bus.res_data, 32'd12);
        chk("add_hi", {31'd0, bus.res_hi}, 32'd0);
        @(negedge clk);
        chk("add_busy_after", {31'd0, bus.busy}, 32'd0);

        // MULTU hold length and Hi/Lo ordering
        send(6'd25, 32'hFFFF_FFFF, 32'd2);
        n25 = 0;
        hc = -1;
        lc = -1;
        for (int i = 0; i < 100 && lc < 0; i++) begin
            @(negedge clk);
            if (bus.alu_signal == 6'd25) n25++;
            if (bus.res_valid && bus.res_hi) begin
                hc = cyc;
                chk("mul_hi_data", bus.res_data, 32'd1);
            end
            if (bus.res_valid && !bus.res_hi) begin
                lc = cyc;
                chk("mul_lo_data", bus.res_data, 32'hFFFF_FFFE);
            end
        end
        chk("mul_hold_cycles", n25, HOLD);
        chk("mul_hi_latency", hc - acc, HOLD + 3);
        chk("mul_lo_latency", lc - acc, HOLD + 4);

        // MULTU then 5 SUBs: fifth blocked until first SUB popped
        send(6'd25, 32'd3, 32'd4);
        m_acc = acc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) send(6'd34, 32'd10, 32'd3);
        chk("fifo_full_backpressure", {31'd0, bus.in_ready}, 32'd0);
        send(6'd34, 32'd10, 32'd3);
        chk("fifth_accept_cycle", acc - m_acc, HOLD + 6);
        wait_drain(200);

        // unsupported op then OR
        e0 = err_pulses;
        r0 = res_pulses;
        send(6'd7, 32'd1, 32'd2);
        send(6'd37, 32'hF0, 32'h0F);
        wait_drain(50);
        chk("bad_op_err_pulses", err_pulses - e0, 32'd1);
        chk("bad_op_results", res_pulses - r0, 32'd1);
        chk("or_data", bus.res_data, 32'hFF);

        // SLT signed and SRL
        send(6'd42, 32'hFFFF_FFFF, 32'd1);
        wait_res(20, c);
        chk("slt_latency", c - acc, 32'd3);
        chk("slt_data", bus.res_data, 32'd1);
        send(6'd2, 32'h80, 32'd3);
        wait_res(20, c);
        chk("srl_latency", c - acc, 32'd3);
        chk("srl_data", bus.res_data, 32'h10);
        wait_drain(20);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 11);
            if (sel == 0) op = 25;
            else if (sel == 1) begin
                op = $urandom_range(0, 63);
                while (op inside {36, 37, 32, 34, 42, 2, 25, 16, 18})
                    op = $urandom_range(0, 63);
            end else begin
                case ($urandom_range(0, 7))
                    0: op = 36;
                    1: op = 37;
                    2: op = 32;
                    3: op = 34;
                    4: op = 42;
                    5: op = 2;
                    6: op = 16;
                    default: op = 18;
                endcase
            end
            send(6'(op), $urandom, $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(3000);

        // reset in the middle of MUL with two ops queued
        send(6'd25, 32'd9, 32'd9);
        send(6'd32, 32'd1, 32'd1);
        send(6'd32, 32'd2, 32'd2);
        n25 = 0;
        for (int i = 0; i < 50 && n25 < 10; i++) begin
            @(negedge clk);
            if (bus.alu_signal == 6'd25) n25++;
        end
        chk("pre_reset_mul_seen", n25, 32'd10);
        reset = 1'b0;
        #1;
        chk_reset_outs("midreset");
        expq.delete();
        r0 = res_pulses;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_ready_after", {31'd0, bus.in_ready}, 32'd1);
        repeat (80) @(negedge clk);
        chk("midreset_no_result", res_pulses - r0, 32'd0);
        chk("midreset_busy", {31'd0, bus.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of buffered operations (power of two, >=2).
REQ-002 Parameter: MULT_HOLD, 35, cycles MULTU code is held on alu_signal before Hi/Lo readout.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
REQ-005 in_valid  in  1  upstream operation valid.
REQ-006 in_ready  out  1  operation buffer can accept; transfer on in_valid&&in_ready at rising edge.
REQ-007 in_op  in  6  operation code (AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, MFHI 16, MFLO 18).
REQ-008 in_a / in_b  in  32 each  operands.
REQ-009 alu_signal  out  6  registered; drives ALU Signal.
REQ-010 alu_dataA / alu_dataB  out  32 each  registered; drive ALU dataA/dataB.
REQ-011 alu_result  in  32  ALU Output; valid one cycle after alu_signal/data applied.
REQ-012 res_valid  out  1  one-cycle pulse per result; no backpressure.
REQ-013 res_data  out  32  captured result, valid while res_valid=1.
REQ-014 res_hi  out  1  1 = res_data is Hi word of MULTU; 0 otherwise.
REQ-015 err  out  1  one-cycle pulse when an unsupported op code is discarded.
REQ-016 busy  out  1  1 while FIFO non-empty or FSM not IDLE.

Function
REQ-017 FIFO: FIFO_DEPTH entries of {op, a, b}, strict in-order; in_ready = !full, no dependence on same-cycle pop; no bypass (push to empty FIFO pops no earlier than next edge).
REQ-018 FSM states: IDLE, EXEC, CAP, MUL, MFHI, HICAP, LOCAP.
REQ-019 IDLE: alu_signal=0, alu_dataA/B hold; if FIFO non-empty, pop head at edge.
REQ-020 Pop of simple op (36,37,32,34,42,2,16,18): load alu_signal/dataA/dataB, go EXEC.
REQ-021 EXEC -> CAP after one cycle; CAP holds alu_signal; at end of CAP res_data<=alu_result, res_valid<=1, res_hi<=0, go IDLE.
REQ-022 Simple op latency: pop edge E -> res_valid high during cycle following edge E+2; next pop no earlier than E+3.
REQ-023 Pop of MULTU: load operands, alu_signal=25, counter=0, go MUL; MUL holds 25 for exactly MULT_HOLD cycles, then MFHI.
REQ-024 MFHI: alu_signal=16 one cycle -> HICAP.
REQ-025 HICAP: alu_signal=18; at end capture alu_result as Hi (res_hi=1, res_valid pulse) -> LOCAP.
REQ-026 LOCAP: alu_signal=18; at end capture alu_result as Lo (res_hi=0, res_valid pulse) -> IDLE.
REQ-027 MULTU: Hi and Lo pulses on consecutive cycles, Hi first; pop edge E -> Lo pulse after edge E+MULT_HOLD+3.
REQ-028 Unsupported op code at pop: discarded, err pulse next cycle, FSM stays IDLE, alu outputs unchanged, no res_valid.
REQ-029 Pushes continue during MUL/EXEC/CAP while FIFO not full; FIFO read pointer advances only on pop.
REQ-030 Pointer wrap-around modulo FIFO_DEPTH; full/empty from extra pointer bit.
REQ-031 res_valid and err are never high in the same cycle.

Reset
REQ-032 reset=0: FSM IDLE, FIFO empty, counter 0, alu_signal=0, alu_dataA/B=0, res_data=0, res_valid=0, res_hi=0, err=0, busy=0, in_ready=0.
REQ-033 After release, in_ready=1 from the first cycle; reset mid-operation abandons the operation with no partial result pulse.

Verification (bench uses behavioural ALU model: 1-cycle registered output, MULTU result into Hi/Lo)
REQ-034 ADD a=5 b=7, accept at edge N -> res_valid=1 after edge N+3, res_data=12, res_hi=0, busy=0 next cycle.
REQ-035 MULTU a=0xFFFFFFFF b=2 -> alu_signal=25 for exactly 35 cycles, then Hi pulse res_data=1 res_hi=1, next cycle Lo pulse res_data=0xFFFFFFFE res_hi=0.
REQ-036 MULTU then, 2 cycles later, 5 back-to-back SUB 10-3 -> 4 accepted, in_ready=0 on 5th until first SUB popped; 5 results of 7 in order after Lo.
REQ-037 in_op=7 then OR 0xF0|0x0F -> err single pulse, no result for op 7; OR gives res_data=0xFF.
REQ-038 Reset asserted at MUL count 10 with 2 ops queued -> all outputs at reset values immediately, no res_valid afterwards, busy=0.
REQ-039 SLT a=0xFFFFFFFF b=1 and SRL a=0x80 b=3 -> res_data equals model output (1 and 0x10) each at REQ-022 latency.
